// File: rtl/vid_pkg.sv
// Shared video timing defaults, the raster counter pair and the sprite motion direction.
package vid_pkg;

    localparam int VID_CW       = 12;
    localparam int VID_H_ACTIVE = 640;
    localparam int VID_H_FP     = 16;
    localparam int VID_H_SYNC   = 96;
    localparam int VID_H_BP     = 48;
    localparam int VID_V_ACTIVE = 480;
    localparam int VID_V_FP     = 10;
    localparam int VID_V_SYNC   = 2;
    localparam int VID_V_BP     = 33;

    typedef struct packed {
        logic [VID_CW-1:0] h;
        logic [VID_CW-1:0] v;
    } video_timing_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

endpackage

// File: rtl/bounce_axis.sv
// One axis of sprite motion: steps by SPEED once per enabled frame, clamping and
// reversing at 0 and MAX. A zero MAX pins the sprite at the origin.
module bounce_axis
    import vid_pkg::*;
#(
    parameter int MAX   = 0,
    parameter int SPEED = 1,
    parameter int CW    = 12
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          step_i,
    output logic [CW-1:0] pos_o
);

    localparam logic [CW:0] MAX_W   = (CW+1)'(MAX);
    localparam logic [CW:0] SPEED_W = (CW+1)'(SPEED);

    logic [CW-1:0] pos_q;
    dir_e          dir_q;
    logic [CW:0]   pos_w;

    assign pos_w = {1'b0, pos_q};

    // Compares run one bit wider than the position so pos+SPEED cannot wrap.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            dir_q <= DIR_INC;
        end else if (step_i && (MAX != 0)) begin
            if (dir_q == DIR_INC) begin
                if (pos_w + SPEED_W >= MAX_W) begin
                    pos_q <= CW'(MAX_W);
                    dir_q <= DIR_DEC;
                end else begin
                    pos_q <= CW'(pos_w + SPEED_W);
                end
            end else begin
                if (pos_w <= SPEED_W) begin
                    pos_q <= '0;
                    dir_q <= DIR_INC;
                end else begin
                    pos_q <= CW'(pos_w - SPEED_W);
                end
            end
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/sprite_timing_gen.sv
// Raster timing generator with a bouncing sprite window. Decoded outputs are registered
// one cycle behind the counters; pix_o is a combinational mux on those registered flags.
module sprite_timing_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int H_FP     = VID_H_FP,
    parameter int H_SYNC   = VID_H_SYNC,
    parameter int H_BP     = VID_H_BP,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int V_FP     = VID_V_FP,
    parameter int V_SYNC   = VID_V_SYNC,
    parameter int V_BP     = VID_V_BP,
    parameter int SYNC_POL = 0,
    parameter int SPR_W    = 225,
    parameter int SPR_H    = 225,
    parameter int SPEED_X  = 2,
    parameter int SPEED_Y  = 2,
    parameter int DW       = 8,
    parameter int CW       = VID_CW
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          move_en_i,
    input  logic [DW-1:0] pix_i,
    input  logic [DW-1:0] bg_i,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic          frame_start_o,
    output logic          spr_req_o,
    output logic [CW-1:0] spr_x_o,
    output logic [CW-1:0] spr_y_o,
    output logic [DW-1:0] pix_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_RST  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_RST  = CW'(V_ACTIVE);

    localparam logic [CW:0] H_ACT_W = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT_W = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_BEG  = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_BEG  = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW:0] SPR_W_W = (CW+1)'(SPR_W);
    localparam logic [CW:0] SPR_H_W = (CW+1)'(SPR_H);

    if (SPR_W > H_ACTIVE) begin : g_err_spr_w
        $error("sprite_timing_gen: SPR_W larger than H_ACTIVE");
    end
    if (SPR_H > V_ACTIVE) begin : g_err_spr_h
        $error("sprite_timing_gen: SPR_H larger than V_ACTIVE");
    end
    if (CW != VID_CW) begin : g_err_cw
        $error("sprite_timing_gen: CW must match the vid_pkg counter width");
    end
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_err_total
        $error("sprite_timing_gen: line or frame length does not fit in CW bits");
    end

    video_timing_t cnt_q, cnt_d;
    logic [CW-1:0] pos_x, pos_y;
    logic [CW:0]   h_w, v_w, px_w, py_w;
    logic          frame_end, step;
    logic          de_c, hs_c, vs_c, req_c;
    logic          hs_q, vs_q, de_q, fs_q, req_q;
    logic [CW-1:0] spr_x_q, spr_y_q;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (cnt_q.h == H_LAST) begin
            cnt_d.h = '0;
            cnt_d.v = (cnt_q.v == V_LAST) ? '0 : cnt_q.v + ONE;
        end else begin
            cnt_d.h = cnt_q.h + ONE;
        end
    end

    assign frame_end = (cnt_q.h == H_LAST) && (cnt_q.v == V_LAST);
    assign step      = frame_end && move_en_i;

    bounce_axis #(.MAX(H_ACTIVE - SPR_W), .SPEED(SPEED_X), .CW(CW)) u_bounce_x (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .step_i (step),
        .pos_o  (pos_x)
    );

    bounce_axis #(.MAX(V_ACTIVE - SPR_H), .SPEED(SPEED_Y), .CW(CW)) u_bounce_y (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .step_i (step),
        .pos_o  (pos_y)
    );

    assign h_w  = {1'b0, cnt_q.h};
    assign v_w  = {1'b0, cnt_q.v};
    assign px_w = {1'b0, pos_x};
    assign py_w = {1'b0, pos_y};

    assign de_c  = (h_w < H_ACT_W) && (v_w < V_ACT_W);
    assign hs_c  = (h_w >= HS_BEG) && (h_w < HS_END);
    assign vs_c  = (v_w >= VS_BEG) && (v_w < VS_END);
    assign req_c = de_c && (h_w >= px_w) && (h_w < px_w + SPR_W_W)
                        && (v_w >= py_w) && (v_w < py_w + SPR_H_W);

    // Reset parks the counters at the start of vertical blanking, so a full blanking
    // interval always precedes the first visible pixel.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '{h: H_RST, v: V_RST};
            hs_q    <= ~SYNC_ON;
            vs_q    <= ~SYNC_ON;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            req_q   <= 1'b0;
            spr_x_q <= '0;
            spr_y_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            hs_q    <= hs_c ? SYNC_ON : ~SYNC_ON;
            vs_q    <= vs_c ? SYNC_ON : ~SYNC_ON;
            de_q    <= de_c;
            fs_q    <= (cnt_q.h == '0) && (cnt_q.v == '0);
            req_q   <= req_c;
            spr_x_q <= req_c ? CW'(h_w - px_w) : '0;
            spr_y_q <= req_c ? CW'(v_w - py_w) : '0;
        end
    end

    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign spr_req_o     = req_q;
    assign spr_x_o       = spr_x_q;
    assign spr_y_o       = spr_y_q;
    assign pix_o         = req_q ? pix_i : (de_q ? bg_i : '0);

endmodule

// File: tb/tb_sprite_timing_gen.sv
// Directed bench for sprite_timing_gen on a 24x12 raster with a 4x3 sprite, plus a
// second instance whose sprite fills the active area so it can never move.
module tb_sprite_timing_gen;

    localparam int H_TOTAL = 24;
    localparam int FRAME   = 288;
    localparam int DW      = 8;
    localparam int CW      = 12;
    localparam logic [DW-1:0] PIX = 8'hA5;
    localparam logic [DW-1:0] BG  = 8'h3C;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          move_en_i = 1'b0;
    logic [DW-1:0] pix_i = PIX;
    logic [DW-1:0] bg_i = BG;
    logic          hs_o, vs_o, de_o, frame_start_o, spr_req_o;
    logic [CW-1:0] spr_x_o, spr_y_o;
    logic [DW-1:0] pix_o;
    logic          z_hs, z_vs, z_de, z_fs, z_req;
    logic [CW-1:0] z_sx, z_sy;
    logic [DW-1:0] z_pix;

    sprite_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .SPR_W(4), .SPR_H(3), .SPEED_X(3), .SPEED_Y(1),
        .DW(DW), .CW(CW)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .move_en_i(move_en_i), .pix_i(pix_i), .bg_i(bg_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .frame_start_o(frame_start_o),
        .spr_req_o(spr_req_o), .spr_x_o(spr_x_o), .spr_y_o(spr_y_o), .pix_o(pix_o)
    );

    sprite_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .SPR_W(16), .SPR_H(8), .SPEED_X(3), .SPEED_Y(1),
        .DW(DW), .CW(CW)
    ) dut_full (
        .clk_i(clk_i), .rst_n(rst_n), .move_en_i(move_en_i), .pix_i(pix_i), .bg_i(bg_i),
        .hs_o(z_hs), .vs_o(z_vs), .de_o(z_de), .frame_start_o(z_fs),
        .spr_req_o(z_req), .spr_x_o(z_sx), .spr_y_o(z_sy), .pix_o(z_pix)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    logic          cap_req[FRAME], cap_de[FRAME], cap_hs[FRAME], cap_vs[FRAME], cap_fs[FRAME];
    logic          cap_zreq[FRAME], ref_req[FRAME];
    logic [CW-1:0] cap_sx[FRAME], cap_sy[FRAME];
    logic [DW-1:0] cap_pix[FRAME];

    // Samples one full frame; the caller is on the frame_start_o sample (index 0).
    task automatic capture_frame();
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk_i);
            cap_req[k]  = spr_req_o;
            cap_de[k]   = de_o;
            cap_hs[k]   = hs_o;
            cap_vs[k]   = vs_o;
            cap_fs[k]   = frame_start_o;
            cap_sx[k]   = spr_x_o;
            cap_sy[k]   = spr_y_o;
            cap_pix[k]  = pix_o;
            cap_zreq[k] = z_req;
        end
    endtask

    task automatic wait_frame_start(output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < 400) begin
            @(negedge clk_i);
            cycles++;
            seen = frame_start_o;
        end
        if (!seen) cycles = -1;
    endtask

    // Sprite origin is the raster position of the first spr_req_o sample in the frame.
    task automatic measure(output int px, output int py, output int cnt, output int zfirst, output int zcnt);
        px = -1; py = -1; cnt = 0; zfirst = -1; zcnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (cap_req[k]) begin
                if (cnt == 0) begin
                    px = k % H_TOTAL;
                    py = k / H_TOTAL;
                end
                cnt++;
            end
            if (cap_zreq[k]) begin
                if (zcnt == 0) zfirst = k;
                zcnt++;
            end
        end
    endtask

    typedef struct {
        int   h;
        int   v;
        logic req;
        int   sx;
        int   sy;
        logic de;
        logic hs;
        logic vs;
        logic fs;
        int   pix;
    } pix_vec_t;

    typedef struct {
        logic move_en;
        int   x;
        int   y;
    } bounce_vec_t;

    pix_vec_t    pv[18];
    bounce_vec_t bv[11];

    initial begin
        int c, px, py, cnt, zfirst, zcnt, diff, hs_low, vs_low, de_cnt;
        bit pix_done;

        // Pixel expectations for a frame with the sprite at (3,1): window h 3..6, v 1..3.
        pv[0]  = '{0, 0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 'h3C};
        pv[1]  = '{2, 1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'h3C};
        pv[2]  = '{3, 1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'hA5};
        pv[3]  = '{6, 1, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'hA5};
        pv[4]  = '{7, 1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'h3C};
        pv[5]  = '{5, 2, 1'b1, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 'hA5};
        pv[6]  = '{3, 3, 1'b1, 0, 2, 1'b1, 1'b1, 1'b1, 1'b0, 'hA5};
        pv[7]  = '{6, 3, 1'b1, 3, 2, 1'b1, 1'b1, 1'b1, 1'b0, 'hA5};
        pv[8]  = '{3, 4, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'h3C};
        pv[9]  = '{3, 0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'h3C};
        pv[10] = '{15, 7, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 'h3C};
        pv[11] = '{16, 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        pv[12] = '{18, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        pv[13] = '{20, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        pv[14] = '{21, 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        pv[15] = '{4, 8, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        pv[16] = '{4, 9, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        pv[17] = '{4, 11, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0};

        // Sprite origin expected during each frame, and move_en_i held through it.
        // X: MAX 12, speed 3. Y: MAX 5, speed 1.
        bv[0]  = '{1'b1, 0, 0};
        bv[1]  = '{1'b0, 3, 1};
        bv[2]  = '{1'b1, 3, 1};
        bv[3]  = '{1'b1, 6, 2};
        bv[4]  = '{1'b1, 9, 3};
        bv[5]  = '{1'b1, 12, 4};
        bv[6]  = '{1'b1, 9, 5};
        bv[7]  = '{1'b1, 6, 4};
        bv[8]  = '{1'b1, 3, 3};
        bv[9]  = '{1'b1, 0, 2};
        bv[10] = '{1'b0, 3, 1};

        repeat (3) @(negedge clk_i);
        check("rst de_o", de_o, 0);
        check("rst hs_o", hs_o, 1);
        check("rst vs_o", vs_o, 1);
        check("rst spr_req_o", spr_req_o, 0);
        check("rst frame_start_o", frame_start_o, 0);
        check("rst spr_x_o", spr_x_o, 0);
        check("rst spr_y_o", spr_y_o, 0);
        check("rst pix_o", pix_o, 0);

        rst_n = 1'b1;
        @(negedge clk_i);
        check("post-release de_o", de_o, 0);
        check("post-release hs_o", hs_o, 1);
        // Counters restart at (16,8): 8 cycles finish that line, 3 more lines of 24,
        // then one register stage -> frame_start_o after 81 clock edges.
        wait_frame_start(c);
        check("first frame_start latency", (c < 0) ? 32'hFFFF_FFFF : c + 1, 81);

        move_en_i = 1'b0;
        capture_frame();
        hs_low = 0; vs_low = 0; de_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k < H_TOTAL && !cap_hs[k]) hs_low++;
            if (!cap_vs[k]) vs_low++;
            if (cap_de[k]) de_cnt++;
            ref_req[k] = cap_req[k];
        end
        check("de_o with frame_start_o", cap_de[0], 1);
        check("hs_o low cycles per line", hs_low, 3);
        check("vs_o low cycles per frame", vs_low, 48);
        check("de_o cycles per frame", de_cnt, 128);
        measure(px, py, cnt, zfirst, zcnt);
        check("reset pos_x", px, 0);
        check("reset pos_y", py, 0);
        check("sprite pixel count", cnt, 12);
        check("full sprite pixel count", zcnt, 128);

        // Frame with motion disabled: window must repeat exactly.
        wait_frame_start(c);
        check("frame period", c, 1);
        capture_frame();
        diff = 0;
        for (int k = 0; k < FRAME; k++) if (cap_req[k] !== ref_req[k]) diff++;
        check("stationary window differences", diff, 0);

        pix_done = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_frame_start(c);
            check("frame period", c, 1);
            move_en_i = bv[i].move_en;
            capture_frame();
            measure(px, py, cnt, zfirst, zcnt);
            check($sformatf("frame %0d pos_x", i), px, bv[i].x);
            check($sformatf("frame %0d pos_y", i), py, bv[i].y);
            check($sformatf("frame %0d sprite count", i), cnt, 12);
            check($sformatf("frame %0d full sprite origin", i), zfirst, 0);
            if (!pix_done && bv[i].x == 3 && bv[i].y == 1) begin
                pix_done = 1'b1;
                for (int j = 0; j < 18; j++) begin
                    int k;
                    k = pv[j].v * H_TOTAL + pv[j].h;
                    check($sformatf("(%0d,%0d) spr_req_o", pv[j].h, pv[j].v), cap_req[k], pv[j].req);
                    check($sformatf("(%0d,%0d) spr_x_o", pv[j].h, pv[j].v), cap_sx[k], pv[j].sx);
                    check($sformatf("(%0d,%0d) spr_y_o", pv[j].h, pv[j].v), cap_sy[k], pv[j].sy);
                    check($sformatf("(%0d,%0d) de_o", pv[j].h, pv[j].v), cap_de[k], pv[j].de);
                    check($sformatf("(%0d,%0d) hs_o", pv[j].h, pv[j].v), cap_hs[k], pv[j].hs);
                    check($sformatf("(%0d,%0d) vs_o", pv[j].h, pv[j].v), cap_vs[k], pv[j].vs);
                    check($sformatf("(%0d,%0d) frame_start_o", pv[j].h, pv[j].v), cap_fs[k], pv[j].fs);
                    check($sformatf("(%0d,%0d) pix_o", pv[j].h, pv[j].v), cap_pix[k], pv[j].pix);
                end
            end
        end

        // Mid-line reset with the sprite at (3,1): pixel (5,2) is inside the window.
        move_en_i = 1'b0;
        wait_frame_start(c);
        check("frame period", c, 1);
        repeat (53) @(negedge clk_i);
        check("pre-reset spr_req_o", spr_req_o, 1);
        check("pre-reset spr_x_o", spr_x_o, 2);
        rst_n = 1'b0;
        @(negedge clk_i);
        check("mid rst de_o", de_o, 0);
        check("mid rst hs_o", hs_o, 1);
        check("mid rst vs_o", vs_o, 1);
        check("mid rst spr_req_o", spr_req_o, 0);
        check("mid rst frame_start_o", frame_start_o, 0);
        check("mid rst spr_x_o", spr_x_o, 0);
        check("mid rst spr_y_o", spr_y_o, 0);
        check("mid rst pix_o", pix_o, 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        wait_frame_start(c);
        check("frame_start latency after mid reset", c, 81);
        capture_frame();
        measure(px, py, cnt, zfirst, zcnt);
        check("post-reset pos_x", px, 0);
        check("post-reset pos_y", py, 0);
        check("post-reset sprite count", cnt, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
